// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller: key codes, FSM state
// encoding and the price/coin lookup helpers.
package vend_pkg;

    localparam logic [3:0] KEY_COIN1  = 4'h1;
    localparam logic [3:0] KEY_COIN2  = 4'h2;
    localparam logic [3:0] KEY_COIN5  = 4'h5;
    localparam logic [3:0] KEY_SEL_A  = 4'hA;
    localparam logic [3:0] KEY_SEL_B  = 4'hB;
    localparam logic [3:0] KEY_SEL_C  = 4'hC;
    localparam logic [3:0] KEY_SEL_D  = 4'hD;
    localparam logic [3:0] KEY_CANCEL = 4'hE;

    localparam logic [7:0] DEF_PRICE_A = 8'd15;
    localparam logic [7:0] DEF_PRICE_B = 8'd20;
    localparam logic [7:0] DEF_PRICE_C = 8'd25;
    localparam logic [7:0] DEF_PRICE_D = 8'd40;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CHECK    = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } vend_state_t;

    // price_tbl packs the four prices as {D, C, B, A}
    function automatic logic [7:0] price_of(input logic [1:0] idx, input logic [31:0] price_tbl);
        logic [7:0] price;
        case (idx)
            2'd0:    price = price_tbl[7:0];
            2'd1:    price = price_tbl[15:8];
            2'd2:    price = price_tbl[23:16];
            2'd3:    price = price_tbl[31:24];
            default: price = price_tbl[7:0];
        endcase
        return price;
    endfunction

    // Zero means "not a coin key"
    function automatic logic [7:0] coin_value(input logic [3:0] code);
        logic [7:0] value;
        case (code)
            KEY_COIN1: value = 8'd1;
            KEY_COIN2: value = 8'd2;
            KEY_COIN5: value = 8'd5;
            default:   value = 8'd0;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/vend_pulse_timer.sv
// Load/count-down timer; done rises once the loaded count has fully elapsed.
module vend_pulse_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    localparam logic [W-1:0] CNT_ZERO = W'(32'd0);
    localparam logic [W-1:0] CNT_ONE  = W'(32'd1);

    logic [W-1:0] count_r;
    logic         done_r;

    // Count down while enabled; done is registered one step ahead of zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= CNT_ZERO;
            done_r  <= 1'b0;
        end else if (load) begin
            count_r <= load_val;
            done_r  <= (load_val == CNT_ZERO);
        end else if (en && (count_r != CNT_ZERO)) begin
            count_r <= count_r - CNT_ONE;
            done_r  <= (count_r == CNT_ONE);
        end else begin
            count_r <= count_r;
            done_r  <= done_r;
        end
    end

    assign done = done_r;

endmodule

// File: rtl/vend_controller.sv
// Vending transaction FSM: key presses to credit, stock-checked vends,
// change and deny events. All outputs come straight from registers.
module vend_controller
    import vend_pkg::*;
#(
    parameter logic [7:0] PRICE_A         = DEF_PRICE_A,
    parameter logic [7:0] PRICE_B         = DEF_PRICE_B,
    parameter logic [7:0] PRICE_C         = DEF_PRICE_C,
    parameter logic [7:0] PRICE_D         = DEF_PRICE_D,
    parameter logic [3:0] INIT_STOCK      = 4'd5,
    parameter logic [7:0] MAX_CREDIT      = 8'd99,
    parameter int         DISPENSE_CYCLES = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic [7:0] credit,
    output logic [7:0] change,
    output logic       change_valid,
    output logic       dispense_on,
    output logic [1:0] dispense_item,
    output logic       deny,
    output logic       busy
);

    localparam logic [31:0] PRICE_TBL = {PRICE_D, PRICE_C, PRICE_B, PRICE_A};
    localparam int          TW        = $clog2(DISPENSE_CYCLES);
    localparam logic [TW-1:0] DISP_LOAD = TW'(DISPENSE_CYCLES - 1);

    vend_state_t state_r;
    logic        key_valid_q_r;
    logic [7:0]  credit_r;
    logic [7:0]  change_r;
    logic        change_valid_r;
    logic        dispense_on_r;
    logic [1:0]  dispense_item_r;
    logic        deny_r;
    logic        busy_r;
    logic [1:0]  item_r;
    logic [3:0]  stock_r [4];

    logic        press_s;
    logic [7:0]  coin_val_s;
    logic        is_coin_s;
    logic        is_sel_s;
    logic        is_cancel_s;
    logic [1:0]  sel_idx_s;
    logic        coin_fits_s;
    logic [7:0]  item_price_s;
    logic        check_ok_s;
    logic        timer_load_s;
    logic        timer_en_s;
    logic        timer_done_s;

    // Key decode and the CHECK-state verdict
    always_comb begin
        press_s     = key_valid & ~key_valid_q_r;
        coin_val_s  = coin_value(key_code);
        is_coin_s   = (coin_val_s != 8'd0);
        is_cancel_s = (key_code == KEY_CANCEL);
        is_sel_s    = 1'b1;
        case (key_code)
            KEY_SEL_A: sel_idx_s = 2'd0;
            KEY_SEL_B: sel_idx_s = 2'd1;
            KEY_SEL_C: sel_idx_s = 2'd2;
            KEY_SEL_D: sel_idx_s = 2'd3;
            default: begin
                sel_idx_s = 2'd0;
                is_sel_s  = 1'b0;
            end
        endcase
        // 9-bit compares keep the ceiling and price tests free of wrap-around
        coin_fits_s  = ({1'b0, credit_r} + {1'b0, coin_val_s}) <= {1'b0, MAX_CREDIT};
        item_price_s = price_of(item_r, PRICE_TBL);
        check_ok_s   = (stock_r[item_r] != 4'd0) && ({1'b0, credit_r} >= {1'b0, item_price_s});
        timer_load_s = (state_r == ST_CHECK) && check_ok_s;
        timer_en_s   = (state_r == ST_DISPENSE);
    end

    vend_pulse_timer #(
        .W (TW)
    ) u_dispense_timer (
        .clk      (clk),
        .rst_n    (reset),
        .load     (timer_load_s),
        .load_val (DISP_LOAD),
        .en       (timer_en_s),
        .done     (timer_done_s)
    );

    // Transaction FSM with its registered outputs and stock counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r         <= ST_IDLE;
            key_valid_q_r   <= 1'b0;
            credit_r        <= 8'd0;
            change_r        <= 8'd0;
            change_valid_r  <= 1'b0;
            dispense_on_r   <= 1'b0;
            dispense_item_r <= 2'd0;
            deny_r          <= 1'b0;
            busy_r          <= 1'b0;
            item_r          <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                stock_r[i] <= INIT_STOCK;
            end
        end else begin
            key_valid_q_r  <= key_valid;
            change_valid_r <= 1'b0;
            deny_r         <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (press_s && is_coin_s) begin
                        if (coin_fits_s) begin
                            credit_r <= credit_r + coin_val_s;
                        end else begin
                            deny_r <= 1'b1;
                        end
                    end else if (press_s && is_sel_s) begin
                        item_r  <= sel_idx_s;
                        state_r <= ST_CHECK;
                        busy_r  <= 1'b1;
                    end else if (press_s && is_cancel_s && (credit_r != 8'd0)) begin
                        change_r       <= credit_r;
                        change_valid_r <= 1'b1;
                        state_r        <= ST_CHANGE;
                        busy_r         <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (check_ok_s) begin
                        credit_r         <= credit_r - item_price_s;
                        stock_r[item_r]  <= stock_r[item_r] - 4'd1;
                        dispense_on_r    <= 1'b1;
                        dispense_item_r  <= item_r;
                        state_r          <= ST_DISPENSE;
                    end else begin
                        deny_r  <= 1'b1;
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_DISPENSE: begin
                    if (timer_done_s) begin
                        dispense_on_r <= 1'b0;
                        if (credit_r != 8'd0) begin
                            change_r       <= credit_r;
                            change_valid_r <= 1'b1;
                            state_r        <= ST_CHANGE;
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_DISPENSE;
                    end
                end
                ST_CHANGE: begin
                    credit_r <= 8'd0;
                    state_r  <= ST_IDLE;
                    busy_r   <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign credit        = credit_r;
    assign change        = change_r;
    assign change_valid  = change_valid_r;
    assign dispense_on   = dispense_on_r;
    assign dispense_item = dispense_item_r;
    assign deny          = deny_r;
    assign busy          = busy_r;

endmodule
